// File: rtl/sr_bank_arbiter.sv
// Round-robin arbiter that serialises set/clear requests onto a shared bank of SR flops.
// Define SR_ARB_VERIFY_EN to add a read-back CHECK state that compares q_in against the written value.
//
// state | meaning
// IDLE  | waiting for a request; a winner is granted and its S/R pulse is driven at the same edge
// ISSUE | pulse is on the bank; it is captured at the closing edge
// CHECK | read back q_in and report completion (only with SR_ARB_VERIFY_EN)
module sr_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int NBITS = 8,
  parameter int AW    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      op,
  input  logic [NREQ*AW-1:0]   addr,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [NBITS-1:0]     s_out,
  output logic [NBITS-1:0]     r_out,
  input  logic [NBITS-1:0]     q_in,
  output logic                 busy,
  output logic                 err,
  input  logic                 err_clr
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
`ifdef SR_ARB_VERIFY_EN
  localparam logic [1:0] CHECK = 2'd2;
`endif

  logic [1:0]       state;
  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    win_l;
  logic             bad_l;

  logic             found;
  logic [PW-1:0]    win;
  logic             op_w;
  logic [AW-1:0]    addr_w;
  logic             bad_w;
  logic [NBITS-1:0] mask_w;
  logic             err_set;

`ifdef SR_ARB_VERIFY_EN
  logic             op_l;
  logic [NBITS-1:0] mask_l;
`else
  logic             unused_q;
  assign unused_q = ^q_in;
`endif

  // First pending request at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[(int'(rr_ptr) + k) % NREQ]) begin
        found = 1'b1;
        win   = PW'((int'(rr_ptr) + k) % NREQ);
      end
    end
  end

  assign op_w   = op[win];
  assign addr_w = addr[int'(win)*AW +: AW];
  assign bad_w  = int'(addr_w) >= NBITS;
  // An out-of-range shift yields zero, so a bad address produces no pulse.
  assign mask_w = NBITS'(1) << addr_w;

  always_comb begin
    err_set = 1'b0;
`ifdef SR_ARB_VERIFY_EN
    if (state == CHECK) begin
      err_set = bad_l | ((|(q_in & mask_l)) != op_l);
    end
`else
    if (state == ISSUE) begin
      err_set = bad_l;
    end
`endif
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      win_l  <= '0;
      bad_l  <= 1'b0;
      gnt    <= '0;
      done   <= '0;
      s_out  <= '0;
      r_out  <= '0;
      err    <= 1'b0;
`ifdef SR_ARB_VERIFY_EN
      op_l   <= 1'b0;
      mask_l <= '0;
`endif
    end else begin
      gnt   <= '0;
      done  <= '0;
      s_out <= '0;
      r_out <= '0;

      // A new error outranks a simultaneous clear.
      if (err_set) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (found) begin
            gnt    <= NREQ'(1) << win;
            rr_ptr <= PW'((int'(win) + 1) % NREQ);
            win_l  <= win;
            bad_l  <= bad_w;
            s_out  <= op_w ? mask_w : '0;
            r_out  <= op_w ? '0 : mask_w;
`ifdef SR_ARB_VERIFY_EN
            op_l   <= op_w;
            mask_l <= mask_w;
`endif
            state  <= ISSUE;
          end
        end
        ISSUE: begin
`ifdef SR_ARB_VERIFY_EN
          state <= CHECK;
`else
          done  <= NREQ'(1) << win_l;
          state <= IDLE;
`endif
        end
`ifdef SR_ARB_VERIFY_EN
        CHECK: begin
          done  <= NREQ'(1) << win_l;
          state <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sr_bank_arbiter.sv
// Directed bench for sr_bank_arbiter with a behavioural SR bank on s_out/r_out/q_in.
// Latency expectations follow SR_ARB_VERIFY_EN (3-cycle ops) or its absence (2-cycle ops).
module tb_sr_bank_arbiter;

  localparam int NREQ  = 4;
  localparam int NBITS = 6;
  localparam int AW    = 3;
`ifdef SR_ARB_VERIFY_EN
  localparam int DONE_LAT = 2;
  localparam logic VERIFY = 1'b1;
`else
  localparam int DONE_LAT = 1;
  localparam logic VERIFY = 1'b0;
`endif

  logic                clk;
  logic                rst;
  logic                err_clr;
  logic                busy;
  logic                err;
  logic [NREQ-1:0]     req;
  logic [NREQ-1:0]     op;
  logic [NREQ-1:0]     gnt;
  logic [NREQ-1:0]     done;
  logic [NREQ*AW-1:0]  addr;
  logic [NBITS-1:0]    s_out;
  logic [NBITS-1:0]    r_out;
  logic [NBITS-1:0]    q_in;
  logic [NBITS-1:0]    bank;
  logic [NBITS-1:0]    q_kill;

  int checks = 0;
  int errors = 0;

  sr_bank_arbiter #(.NREQ(NREQ), .NBITS(NBITS), .AW(AW)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .addr(addr),
    .gnt(gnt), .done(done), .s_out(s_out), .r_out(r_out), .q_in(q_in),
    .busy(busy), .err(err), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bank <= '0;
    else     bank <= (bank | s_out) & ~r_out;
  end
  assign q_in = bank & ~q_kill;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_req(input int i, input logic o, input logic [AW-1:0] a);
    req[i] = 1'b1;
    op[i]  = o;
    addr[i*AW +: AW] = a;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("sr_excl", 32'(s_out & r_out), 0);
      check("sr_pop", 32'($countones(s_out | r_out) <= 1), 1);
      check("gnt_pop", 32'($countones(gnt) <= 1), 1);
      check("done_pop", 32'($countones(done) <= 1), 1);
    end
  end

  initial begin
    int seen;
    rst = 1'b1; req = '0; op = '0; addr = '0; err_clr = 1'b0; q_kill = '0;
    #12;
    check("rst_gnt", gnt, 0);
    check("rst_done", done, 0);
    check("rst_s", s_out, 0);
    check("rst_r", r_out, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    rst = 1'b0;

    // requester 0 sets bit 3
    set_req(0, 1'b1, 3'd3);
    tick();
    check("t1_gnt", gnt, 4'b0001);
    check("t1_s", s_out, 6'h08);
    check("t1_r", r_out, 0);
    check("t1_busy", busy, 1);
    check("t1_done_early", done, 0);
    req[0] = 1'b0;
    tick();
    check("t1_s_drop", s_out, 0);
    check("t1_gnt_drop", gnt, 0);
    check("t1_bank3", bank[3], 1);
    tick(DONE_LAT - 1);
    check("t1_done", done, 4'b0001);
    check("t1_err", err, 0);
    tick();
    check("t1_done_drop", done, 0);
    check("t1_idle", busy, 0);

    // all four requesting from a fresh reset
    rst = 1'b1; #1; rst = 1'b0;
    req = 4'b1111; op = 4'b1111;
    addr = {3'd4, 3'd2, 3'd1, 3'd0};
    for (int i = 0; i < NREQ; i++) begin
      tick();
      check("rr_gnt", gnt, 32'(1) << i);
      req[i] = 1'b0;
      tick(DONE_LAT);
      check("rr_done", done, 32'(1) << i);
    end
    check("rr_bank", bank, 6'h17);
    req = 4'b1001;
    tick();
    check("rr_wrap", gnt, 4'b0001);
    req[0] = 1'b0;
    tick(DONE_LAT);
    tick();
    check("rr_fair", gnt, 4'b1000);
    req[3] = 1'b0;
    tick(DONE_LAT + 1);

    // requester 2 sets then clears bit 5
    set_req(2, 1'b1, 3'd5);
    tick();
    check("t3_gnt", gnt, 4'b0100);
    check("t3_s", s_out, 6'h20);
    check("t3_r", r_out, 0);
    req = '0;
    tick(DONE_LAT);
    check("t3_done", done, 4'b0100);
    check("t3_q_set", bank[5], 1);
    set_req(2, 1'b0, 3'd5);
    tick();
    check("t3_gnt2", gnt, 4'b0100);
    check("t3_s2", s_out, 0);
    check("t3_r2", r_out, 6'h20);
    req = '0;
    tick(DONE_LAT);
    check("t3_done2", done, 4'b0100);
    check("t3_q_clr", bank[5], 0);
    tick();

    // bad address, err clear, set-wins-over-clear
    set_req(0, 1'b1, 3'd7);
    tick();
    check("t4_gnt", gnt, 4'b0001);
    check("t4_s", s_out, 0);
    check("t4_r", r_out, 0);
    req = '0;
    tick(DONE_LAT);
    check("t4_done", done, 4'b0001);
    check("t4_err", err, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t4_err_clr", err, 0);
    set_req(0, 1'b0, 3'd6);
    tick();
    req = '0;
    err_clr = 1'b1;
    tick(DONE_LAT);
    check("t4_set_wins", err, 1);
    check("t4_done2", done, 4'b0001);
    err_clr = 1'b0;
    tick();
    check("t4_sticky", err, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t4_clr2", err, 0);

    // read-back mismatch on bit 2 (only flagged with the verify build)
    set_req(1, 1'b1, 3'd2);
    tick();
    check("t5_gnt", gnt, 4'b0010);
    req = '0;
    q_kill = 6'b000100;
    tick(DONE_LAT);
    check("t5_done", done, 4'b0010);
    check("t5_err", err, 32'(VERIFY));
    q_kill = '0;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    // reset during ISSUE aborts the op and resets the pointer
    set_req(2, 1'b1, 3'd1);
    tick();
    check("t6_gnt", gnt, 4'b0100);
    check("t6_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("t6_s", s_out, 0);
    check("t6_r", r_out, 0);
    check("t6_gnt0", gnt, 0);
    check("t6_busy0", busy, 0);
    #1;
    rst = 1'b0;
    req = '0;
    seen = 0;
    repeat (DONE_LAT + 2) begin
      tick();
      if (done != 0) seen++;
    end
    check("t6_no_done", seen, 0);
    set_req(1, 1'b1, 3'd0);
    set_req(3, 1'b1, 3'd0);
    tick();
    check("t6_ptr0", gnt, 4'b0010);
    req[1] = 1'b0;
    tick(DONE_LAT);
    tick();
    check("t6_next", gnt, 4'b1000);
    req[3] = 1'b0;
    tick(DONE_LAT + 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sr_bank_arbiter.md
Name: sr_bank_arbiter

Overview:
- Shares a bank of NBITS external SR flip-flops (asynchronous active-high reset, posedge clk) among NREQ requesters.
- Each requester asks to set or clear one bit of the bank. The arbiter grants one request at a time in round-robin order.
- It drives a single-cycle S or R pulse to the addressed flop, never S=R=1, and reads back q to confirm the write.

Parameters:
NREQ, 4, number of requesters
NBITS, 8, number of SR flops in the shared bank
AW, 3, address width per requester; must satisfy 2**AW >= NBITS

Ports:
- clk  in  1  clock, posedge
- rst  in  1  reset, asynchronous, active-high
- req  in  NREQ  request per requester
- op  in  NREQ  op per requester: 1 = set, 0 = clear
- addr  in  NREQ*AW  bit address per requester; requester i uses addr[i*AW +: AW]
- gnt  out  NREQ  one-hot grant pulse, 1 cycle
- done  out  NREQ  one-hot completion pulse, 1 cycle
- s_out  out  NBITS  S inputs of the bank
- r_out  out  NBITS  R inputs of the bank
- q_in  in  NBITS  Q outputs of the bank
- busy  out  1  high whenever state != IDLE
- err  out  1  sticky error flag
- err_clr  in  1  clears err

Behaviour:
- Clock and reset: clk, posedge. rst is asynchronous, active-high.
- Reset values: gnt=0, done=0, s_out=0, r_out=0, busy=0, err=0, state=IDLE, rr_ptr=0. All outputs are registered.
- States: IDLE, ISSUE, CHECK.
- IDLE, at a clock edge with any req set:
  - Winner = first set req scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
  - Latch op[w] and addr[w]; gnt<=onehot(w); rr_ptr<=(w+1)%NREQ; state<=ISSUE.
  - If addr < NBITS: s_out[addr]<=op, r_out[addr]<=~op.
  - If addr >= NBITS: no S/R pulse; a flag records bad_addr.
- IDLE with no req: all pulses 0, rr_ptr unchanged.
- ISSUE (1 cycle; the bank captures the pulse at the closing edge): gnt<=0, s_out<=0, r_out<=0, state<=CHECK.
- CHECK (1 cycle):
  - mismatch = bad_addr or q_in[addr] != op.
  - done<=onehot(w); err<=1 if mismatch; state<=IDLE.
- done is high in the following IDLE cycle.
- Throughput and latency: 3 cycles per operation. gnt appears 1 cycle after req is sampled; done appears 2 cycles after gnt.
- Handshake: a requester keeps req and its op/addr stable until it sees gnt. A req still high in the cycle done is asserted is treated as a new request.
- Invariants:
  - s_out & r_out == 0 at all times.
  - popcount(s_out|r_out) <= 1.
  - popcount(gnt) <= 1 and popcount(done) <= 1.
- err_clr: clears err at the next edge. If err_clr and a new error occur in the same cycle, set wins and err stays 1.
- Reset mid-operation: returns to IDLE immediately. All pulses drop, the in-flight op is aborted with no done, and rr_ptr returns to 0.
- Simultaneous requests: only the winner is granted. Losers stay pending and are served in later rounds, so each requester waits at most NREQ-1 operations.

Optional Feature:
- Macro: SR_ARB_VERIFY_EN.
- Defined: read-back CHECK state as described above; operation is 3 cycles.
- Undefined:
  - No CHECK state. At the ISSUE edge the block sets done<=onehot(w) and state<=IDLE, so an operation takes 2 cycles.
  - q_in is unused. err is raised only for bad_addr.

Test Plan:
- Reset, then req=4'b0001, op[0]=1, addr0=3 -> gnt=0001 one cycle later; s_out=8'h08 for exactly 1 cycle; r_out=0; done=0001 two cycles after gnt; err=0.
- All four req held high together, each dropped on its gnt -> gnt sequence 0001, 0010, 0100, 1000 at 3-cycle spacing; rr_ptr wraps to 0.
- Set then clear of bit 5 by requester 2 -> s_out=8'h20 pulse, then r_out=8'h20 pulse; s_out&r_out==0 on every cycle; bank q[5] goes 1 then 0.
- addr0=7 with NBITS=6 -> no S/R pulse, done=0001, err=1. Then err_clr=1 -> err=0 next cycle. err_clr coinciding with a new error -> err stays 1.
- SR_ARB_VERIFY_EN defined, bench forces q_in[2]=0 while requester 1 sets bit 2 -> err=1 in the cycle done=0010.
- rst asserted during ISSUE -> s_out, r_out, gnt, busy go to 0 immediately; no done pulse; next grant starts scanning from requester 0.
